if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word fetches to instruction memory over a req/ready handshake that tolerates variable latency.
- Absorbs hazard-unit stalls and branch/jump redirects.
- Presents {PC+4, instruction, valid} to IF/ID each cycle; when no valid instruction is available, it presents the pipeline bubble encoding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, number of consecutive wait cycles on one fetch before fetch_error is raised.
- BUBBLE_INSTR, 32'hFC00_0000, bubble/NOP encoding driven on instr_OUT when fetch_valid=0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- PCwrite  input  1  from hazard unit; 1 = IF/ID accepts this cycle, 0 = stall.
- redirect  input  1  branch/jump taken; 1-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch word address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  input  1  memory completes the request this cycle; imem_rdata is valid.
- imem_rdata  input  32  fetched instruction.
- PC_OUT  output  32  fetched address + 4, to IF/ID PC_IN.
- instr_OUT  output  32  instruction to IF/ID instr_IN; BUBBLE_INSTR when not valid.
- fetch_valid  output  1  PC_OUT/instr_OUT carry a real instruction this cycle.
- fetch_error  output  1  sticky; a fetch waited more than TIMEOUT cycles.

Behaviour:

Registers:
- pc: next address to fetch.
- addr_q: address of the outstanding request.
- buf_q: held instruction.
- state.
- wait_cnt: 8 bits, saturating.
- fetch_error.

Reset (async, active-high):
- pc = addr_q = RESET_PC, state = REQ, buf_q = BUBBLE_INSTR, wait_cnt = 0, fetch_error = 0.
- While reset is asserted, imem_req = 0, fetch_valid = 0, instr_OUT = BUBBLE_INSTR, PC_OUT = RESET_PC + 4.

States:
- REQ:
  - imem_req = 1, imem_addr = addr_q.
  - fetch_valid = imem_ready & ~redirect. When valid, instr_OUT = imem_rdata (combinational) and PC_OUT = addr_q + 4.
  - redirect (any ready): pc, addr_q <= {redirect_pc[31:2], 2'b00}.
    - If imem_ready=1, stay in REQ.
    - If imem_ready=0, go to DISCARD with addr_q unchanged (the outstanding request must complete at its original address), and load only pc with the target.
  - imem_ready & PCwrite: instruction consumed; pc, addr_q <= addr_q + 4; stay in REQ. Back-to-back fetches give 1 instruction/cycle with zero-wait memory.
  - imem_ready & ~PCwrite: buf_q <= imem_rdata; go to HOLD.
  - ~imem_ready: wait_cnt++.
- HOLD:
  - imem_req = 0, fetch_valid = ~redirect, instr_OUT = buf_q, PC_OUT = addr_q + 4.
  - redirect: pc, addr_q <= target; go to REQ.
  - PCwrite: pc, addr_q <= addr_q + 4; go to REQ.
  - Otherwise stay; outputs stable for any number of stall cycles.
- DISCARD:
  - imem_req = 1, imem_addr = addr_q (old address), fetch_valid = 0.
  - On imem_ready: data dropped; addr_q <= pc; go to REQ.
  - A further redirect while in DISCARD overwrites pc only; the last redirect wins.

Priority and counter rules:
- Priority: reset > redirect > PCwrite.
- redirect suppresses fetch_valid in the same cycle. The instruction on the wrong path is never presented.
- wait_cnt clears on every imem_ready and on every state entry.
- fetch_error sets when wait_cnt reaches TIMEOUT and clears only on reset. Fetching continues regardless.

Arithmetic:
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- PC_OUT is always addr_q + 4.

Test Plan:
1. Reset, zero-wait memory, PCwrite=1 held → imem_addr 0x0, 0x4, 0x8 on consecutive cycles; PC_OUT 0x4, 0x8, 0xC; fetch_valid=1 from the first cycle after reset deasserts.
2. 3-cycle memory latency at addr 0x10 → imem_addr held at 0x10 for 3 cycles, fetch_valid=0, instr_OUT=0xFC000000; on the ready cycle, fetch_valid=1 and PC_OUT=0x14.
3. Ready with PCwrite=0 for 4 cycles, then 1 → HOLD. instr_OUT=buf_q stable, imem_req=0; on release, next imem_addr = previous addr + 4 and no instruction is lost or duplicated.
4. redirect to 0x0000_0103 while waiting at addr 0x20 → imem_addr stays 0x20 until ready, that data is dropped (fetch_valid=0), then the next request is at 0x100.
5. redirect coincident with imem_ready and PCwrite=0 → fetch_valid=0, no HOLD entered, next imem_addr = target.
6. memory never ready, TIMEOUT=16 → fetch_error rises after 16 wait cycles and stays 1; asynchronous reset mid-wait clears it immediately, without a clock edge.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage in front of the IF/ID register.
// Owns the program counter and fetches words over a req/ready handshake
// that tolerates variable memory latency. Hazard stalls park the fetched
// word in a hold buffer. Redirects squash the wrong-path instruction.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   PCwrite      1 = IF/ID accepts this cycle, 0 = stall
//   redirect     branch/jump taken (1-cycle pulse)
//   redirect_pc  redirect target; bits [1:0] forced to zero
//   imem_req     fetch request to instruction memory
//   imem_addr    fetch word address, stable while waiting
//   imem_ready   memory completes the request this cycle
//   imem_rdata   fetched instruction
//   PC_OUT       fetched address + 4
//   instr_OUT    instruction, or BUBBLE_INSTR when not valid
//   fetch_valid  PC_OUT/instr_OUT carry a real instruction
//   fetch_error  sticky timeout flag
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned TIMEOUT      = 16,
   parameter logic [31:0] BUBBLE_INSTR = 32'hFC00_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCwrite,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_OUT,
   output logic [31:0] instr_OUT,
   output logic        fetch_valid,
   output logic        fetch_error
);

   typedef enum logic [1:0] {StReq, StHold, StDiscard} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] buf_q, buf_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        fetch_error_q, fetch_error_d;

   logic [31:0] target;
   logic [31:0] addr_inc;
   logic [7:0]  wait_inc;

   // Masking rather than slicing keeps the target word-aligned.
   assign target   = redirect_pc & 32'hFFFF_FFFC;
   assign addr_inc = addr_q + 32'd4;
   assign wait_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      addr_d        = addr_q;
      buf_d         = buf_q;
      wait_cnt_d    = wait_cnt_q;
      fetch_error_d = fetch_error_q;

      unique case (state_q)
         StReq: begin
            if (redirect) begin
               pc_d = target;
               if (imem_ready) begin
                  addr_d     = target;
                  wait_cnt_d = 8'd0;
               end else begin
                  // The in-flight request must finish at its old address.
                  state_d    = StDiscard;
                  wait_cnt_d = 8'd0;
               end
            end else if (imem_ready) begin
               wait_cnt_d = 8'd0;
               if (PCwrite) begin
                  pc_d   = addr_inc;
                  addr_d = addr_inc;
               end else begin
                  buf_d   = imem_rdata;
                  state_d = StHold;
               end
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         StHold: begin
            if (redirect) begin
               pc_d       = target;
               addr_d     = target;
               state_d    = StReq;
               wait_cnt_d = 8'd0;
            end else if (PCwrite) begin
               pc_d       = addr_inc;
               addr_d     = addr_inc;
               state_d    = StReq;
               wait_cnt_d = 8'd0;
            end
         end
         StDiscard: begin
            // Last redirect wins; only pc tracks it until the old fetch drains.
            if (redirect) begin
               pc_d = target;
            end
            if (imem_ready) begin
               addr_d     = pc_d;
               state_d    = StReq;
               wait_cnt_d = 8'd0;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         default: begin
            state_d    = StReq;
            wait_cnt_d = 8'd0;
         end
      endcase

      if ({24'd0, wait_cnt_d} >= TIMEOUT) begin
         fetch_error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StReq;
         pc_q          <= RESET_PC;
         addr_q        <= RESET_PC;
         buf_q         <= BUBBLE_INSTR;
         wait_cnt_q    <= 8'd0;
         fetch_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         addr_q        <= addr_d;
         buf_q         <= buf_d;
         wait_cnt_q    <= wait_cnt_d;
         fetch_error_q <= fetch_error_d;
      end
   end

   // Outputs depend on imem_ready/redirect combinationally so a zero-wait
   // memory delivers one instruction per cycle.
   always_comb begin
      imem_req    = 1'b0;
      fetch_valid = 1'b0;
      instr_OUT   = BUBBLE_INSTR;
      if (!reset) begin
         unique case (state_q)
            StReq: begin
               imem_req    = 1'b1;
               fetch_valid = imem_ready & ~redirect;
               if (fetch_valid) instr_OUT = imem_rdata;
            end
            StHold: begin
               fetch_valid = ~redirect;
               if (fetch_valid) instr_OUT = buf_q;
            end
            StDiscard: begin
               imem_req = 1'b1;
            end
            default: begin
               imem_req = 1'b0;
            end
         endcase
      end
   end

   assign imem_addr   = addr_q;
   assign PC_OUT      = addr_inc;
   assign fetch_error = fetch_error_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

   localparam logic [31:0] BUB = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCwrite;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] PC_OUT;
   logic [31:0] instr_OUT;
   logic        fetch_valid;
   logic        fetch_error;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic        err;
   } exp_t;

   exp_t sb[$];

   if_fetch_unit #(
      .RESET_PC    (32'h0000_0000),
      .TIMEOUT     (16),
      .BUBBLE_INSTR(BUB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .PCwrite    (PCwrite),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .PC_OUT     (PC_OUT),
      .instr_OUT  (instr_OUT),
      .fetch_valid(fetch_valid),
      .fetch_error(fetch_error)
   );

   always #5 clk = ~clk;

   // Memory content model: each word is a distinct function of its address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic push(input logic r, input logic [31:0] a, input logic v,
                       input logic [31:0] i, input logic [31:0] p, input logic e);
      exp_t x;
      x.req = r; x.addr = a; x.valid = v; x.instr = i; x.pc = p; x.err = e;
      sb.push_back(x);
   endtask

   task automatic check(input string tag);
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      assert (imem_req === e.req) else begin
         n_fail++;
         $error("FAIL %s imem_req got %0b exp %0b", tag, imem_req, e.req);
      end
      if (e.req) begin
         n_tests++;
         assert (imem_addr === e.addr) else begin
            n_fail++;
            $error("FAIL %s imem_addr got %h exp %h", tag, imem_addr, e.addr);
         end
      end
      n_tests++;
      assert (fetch_valid === e.valid) else begin
         n_fail++;
         $error("FAIL %s fetch_valid got %0b exp %0b", tag, fetch_valid, e.valid);
      end
      n_tests++;
      assert (instr_OUT === e.instr) else begin
         n_fail++;
         $error("FAIL %s instr_OUT got %h exp %h", tag, instr_OUT, e.instr);
      end
      n_tests++;
      assert (PC_OUT === e.pc) else begin
         n_fail++;
         $error("FAIL %s PC_OUT got %h exp %h", tag, PC_OUT, e.pc);
      end
      n_tests++;
      assert (fetch_error === e.err) else begin
         n_fail++;
         $error("FAIL %s fetch_error got %0b exp %0b", tag, fetch_error, e.err);
      end
   endtask

   // One clock cycle: drive inputs, record expectation, sample at negedge.
   task automatic step(input string tag, input logic rdy, input logic pcw,
                       input logic rd, input logic [31:0] rpc, input logic [31:0] rdata,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ee);
      imem_ready  = rdy;
      PCwrite     = pcw;
      redirect    = rd;
      redirect_pc = rpc;
      imem_rdata  = rdata;
      push(er, ea, ev, ei, ep, ee);
      @(negedge clk);
      check(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      PCwrite     = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_ready  = 1'b1;
      imem_rdata  = 32'h1234_5678;
      #2;
      push(1'b0, 32'h0, 1'b0, BUB, 32'h4, 1'b0);
      check("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Zero-wait streaming
      step("seq0", 1, 1, 0, 0, mem(32'h0), 1, 32'h0, 1, mem(32'h0), 32'h4, 0);
      step("seq1", 1, 1, 0, 0, mem(32'h4), 1, 32'h4, 1, mem(32'h4), 32'h8, 0);
      step("seq2", 1, 1, 0, 0, mem(32'h8), 1, 32'h8, 1, mem(32'h8), 32'hC, 0);
      step("seq3", 1, 1, 0, 0, mem(32'hC), 1, 32'hC, 1, mem(32'hC), 32'h10, 0);

      // 3-cycle latency at 0x10
      for (int k = 0; k < 3; k++)
         step("lat_wait", 0, 1, 0, 0, 32'hBAD0_0000, 1, 32'h10, 0, BUB, 32'h14, 0);
      step("lat_rdy", 1, 1, 0, 0, mem(32'h10), 1, 32'h10, 1, mem(32'h10), 32'h14, 0);

      // Stall: ready with PCwrite=0 enters HOLD, buffer must survive rdata changes
      step("hold_in", 1, 0, 0, 0, mem(32'h14), 1, 32'h14, 1, mem(32'h14), 32'h18, 0);
      for (int k = 0; k < 3; k++)
         step("hold_stall", 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 32'h14, 1, mem(32'h14),
              32'h18, 0);
      step("hold_rel", 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 32'h14, 1, mem(32'h14), 32'h18, 0);
      step("hold_next", 1, 1, 0, 0, mem(32'h18), 1, 32'h18, 1, mem(32'h18), 32'h1C, 0);
      step("seq_1c", 1, 1, 0, 0, mem(32'h1C), 1, 32'h1C, 1, mem(32'h1C), 32'h20, 0);

      // Redirect while waiting: old request drains, data dropped
      step("disc_redir", 0, 1, 1, 32'h0000_0103, 32'hBAD0_0000, 1, 32'h20, 0, BUB,
           32'h24, 0);
      step("disc_wait", 0, 1, 0, 0, 32'hBAD0_0000, 1, 32'h20, 0, BUB, 32'h24, 0);
      step("disc_drop", 1, 1, 0, 0, mem(32'h20), 1, 32'h20, 0, BUB, 32'h24, 0);
      step("disc_tgt", 1, 1, 0, 0, mem(32'h100), 1, 32'h100, 1, mem(32'h100), 32'h104, 0);

      // Redirect with ready and PCwrite=0: squashed, no HOLD
      step("rdy_redir", 1, 0, 1, 32'h0000_0200, mem(32'h104), 1, 32'h104, 0, BUB,
           32'h108, 0);
      step("rdy_tgt", 1, 1, 0, 0, mem(32'h200), 1, 32'h200, 1, mem(32'h200), 32'h204, 0);

      // Wrap-around at the top of the address space
      step("wrap_redir", 1, 1, 1, 32'hFFFF_FFFE, mem(32'h204), 1, 32'h204, 0, BUB,
           32'h208, 0);
      step("wrap_top", 1, 1, 0, 0, mem(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 1,
           mem(32'hFFFF_FFFC), 32'h0, 0);

      // Timeout at address 0: error after 16 wait cycles, sticky
      for (int k = 0; k < 16; k++)
         step("to_pre", 0, 1, 0, 0, 32'hBAD0_0000, 1, 32'h0, 0, BUB, 32'h4, 0);
      for (int k = 0; k < 4; k++)
         step("to_post", 0, 1, 0, 0, 32'hBAD0_0000, 1, 32'h0, 0, BUB, 32'h4, 1);

      // Asynchronous reset clears the error without a clock edge
      reset = 1'b1;
      #1;
      push(1'b0, 32'h0, 1'b0, BUB, 32'h4, 1'b0);
      check("async_rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      step("post_rst", 1, 1, 0, 0, mem(32'h0), 1, 32'h0, 1, mem(32'h0), 32'h4, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
